// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM encodings and result-word field offsets for the ALU units
package alu_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_ITER  = 2'd2;
  localparam logic [1:0] S_SAVE  = 2'd3;
  // Result word layout for an ALU of width dw: {id, dz_flag, quotient, remainder}
  function automatic int rem_lsb();
    return 0;
  endfunction
  function automatic int quo_lsb(input int dw);
    return dw / 2;
  endfunction
  function automatic int dz_bit(input int dw);
    return dw;
  endfunction
  function automatic int id_lsb(input int dw);
    return dw + 1;
  endfunction
endpackage

// File: rtl/add_sub.sv
// add_sub: W-bit adder/subtractor; in subtract mode cout=1 means a >= b
module add_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout
);
  // Two's complement subtract as a + ~b + 1
  always_comb {cout, s} = {1'b0, a} + {1'b0, sub ? ~b : b} + (W+1)'(sub);
endmodule

// File: rtl/d_ff_async_en.sv
// d_ff_async_en: W-bit register with enable and asynchronous active-low clear
module d_ff_async_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Clear on reset, otherwise load when enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/div_fsm.sv
// div_fsm: sequential restoring divider with valid/ready/written handshake
module div_fsm
  import alu_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int ID_SIZE   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_SIZE/2-1:0]         a_in,
  input  logic [DATA_SIZE/2-1:0]         b_in,
  input  logic [ID_SIZE-1:0]             id_div,
  input  logic                           d_valid_data,
  input  logic                           ready_f_res,
  input  logic                           div_written,
  output logic                           d_ready_data,
  output logic                           d_valid_res,
  output logic [DATA_SIZE+ID_SIZE:0]     result_div,
  output logic                           start
);
  localparam int DIV_DATA_SIZE    = DATA_SIZE / 2;
  localparam int DIV_COUNTER_SIZE = $clog2(DIV_DATA_SIZE) + 1;
  localparam int W  = DIV_DATA_SIZE;
  localparam int CW = DIV_COUNTER_SIZE;
  localparam int RL = rem_lsb();
  localparam int QL = quo_lsb(DATA_SIZE);
  localparam int DB = dz_bit(DATA_SIZE);
  localparam int IL = id_lsb(DATA_SIZE);

  logic [1:0]         state, state_nxt;
  logic [W-1:0]       a_reg, b_reg, q_reg, r_reg, q_d, r_d;
  logic [ID_SIZE-1:0] id_reg, res_id;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               dz, accept, in_check, in_iter, bz, done, cout;
  logic [W:0]         t;
  logic               unused_t;

  assign in_check     = state == S_CHECK;
  assign in_iter      = state == S_ITER;
  assign d_ready_data = rst_n & (state == S_IDLE) & ready_f_res;
  assign d_valid_res  = state == S_SAVE;
  assign accept       = d_valid_data & d_ready_data;
  assign bz           = b_reg == '0;
  assign cnt_nxt      = cnt + CW'(1);
  assign done         = cnt_nxt == CW'(W);
  assign unused_t     = t[W];

  // Trial subtraction of the divisor from the shifted partial remainder
  add_sub #(.W(W + 1)) u_sub (
    .a(({r_reg, q_reg[W-1]})), .b({1'b0, b_reg}), .sub(1'b1), .s(t), .cout(cout)
  );

  // Next state: accept in IDLE, branch on divide-by-zero, count bits, wait for write-back
  always_comb
    state_nxt = state == S_IDLE  ? (accept ? S_CHECK : S_IDLE) :
                state == S_CHECK ? (bz ? S_SAVE : S_ITER) :
                state == S_ITER  ? (done ? S_SAVE : S_ITER) :
                                   (div_written ? S_IDLE : S_SAVE);

  // Quotient/remainder update: init in CHECK, restoring step in ITER
  always_comb begin
    q_d = in_check ? (bz ? '1 : a_reg) : {q_reg[W-2:0], cout};
    r_d = in_check ? (bz ? a_reg : '0) : (cout ? t[W-1:0] : {r_reg[W-2:0], q_reg[W-1]});
  end

  // Result word assembled from the result registers at their field offsets
  always_comb begin
    result_div = '0;
    result_div[RL +: W]       = r_reg;
    result_div[QL +: W]       = q_reg;
    result_div[DB]            = dz;
    result_div[IL +: ID_SIZE] = res_id;
  end

  d_ff_async_en #(.W(2))       u_state (.clk, .rst_n, .en(1'b1), .d(state_nxt), .q(state));
  d_ff_async_en #(.W(1))       u_start (.clk, .rst_n, .en(1'b1), .d(accept), .q(start));
  d_ff_async_en #(.W(W))       u_a     (.clk, .rst_n, .en(accept), .d(a_in), .q(a_reg));
  d_ff_async_en #(.W(W))       u_b     (.clk, .rst_n, .en(accept), .d(b_in), .q(b_reg));
  d_ff_async_en #(.W(ID_SIZE)) u_id    (.clk, .rst_n, .en(accept), .d(id_div), .q(id_reg));
  d_ff_async_en #(.W(CW))      u_cnt   (.clk, .rst_n, .en(in_check | in_iter),
                                        .d(in_iter ? cnt_nxt : '0), .q(cnt));
  d_ff_async_en #(.W(W))       u_q     (.clk, .rst_n, .en(in_check | in_iter), .d(q_d), .q(q_reg));
  d_ff_async_en #(.W(W))       u_r     (.clk, .rst_n, .en(in_check | in_iter), .d(r_d), .q(r_reg));
  d_ff_async_en #(.W(1))       u_dz    (.clk, .rst_n, .en(in_check), .d(bz), .q(dz));
  d_ff_async_en #(.W(ID_SIZE)) u_rid   (.clk, .rst_n, .en(in_check), .d(id_reg), .q(res_id));
endmodule
